pe_acc: RTL
===========

PE_ACC -- requirements
Module: pe_acc

Interface
REQ-001 SHALL have parameter BW, default 8, operand bitwidth.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator/result width; ACC_W >= 2*BW enforced by elaboration check.
REQ-003 SHALL have parameter SIGNED, default 0, 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 SHALL have parameter SAT, default 1, 1 = saturating accumulate, 0 = wrap-around.
REQ-005 SHALL have port clk, input, 1, single clock, posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports iRow / iCol, input, BW each, operands from west / north neighbour.
REQ-008 SHALL have ports iValid / iClr / iLast, input, 1 each: beat valid, first beat of tile, final beat of tile.
REQ-009 SHALL have ports oRow / oCol, output, BW each, registered copies of iRow / iCol to east / south neighbour.
REQ-010 SHALL have ports oValid / oClr / oLast, output, 1 each, registered copies of iValid / iClr / iLast.
REQ-011 SHALL have port oRes, output, ACC_W, last completed tile result.
REQ-012 SHALL have port oResValid, output, 1, one-cycle pulse when oRes updates.
REQ-013 SHALL have port oOvf, output, 1, overflow flag for the tile in oRes.

Function
REQ-014 SHALL forward iRow, iCol, iValid, iClr and iLast to the matching outputs with exactly 1 cycle latency, every cycle, regardless of FSM state.
REQ-015 SHALL use FSM states IDLE (no tile open), ACC (tile open) and DONE (result pulse cycle).
REQ-016 SHALL treat a beat as accepted only when iValid=1; iClr/iLast SHALL be ignored when iValid=0.
REQ-017 SHALL, on an accepted beat with iClr=1 in any state, load acc = ext(iRow*iCol), clear the tile overflow flag and enter ACC (or DONE when iLast=1).
REQ-018 SHALL, in ACC, on an accepted beat with iClr=0, update acc = acc + ext(iRow*iCol).
REQ-019 SHALL ignore accepted beats with iClr=0 in IDLE or DONE (no accumulation; forwarding unaffected).
REQ-020 SHALL form the product at 2*BW bits, then sign-extend (SIGNED=1) or zero-extend (SIGNED=0) to ACC_W.
REQ-021 SHALL, when an add overflows ACC_W, set the tile overflow flag and clamp acc to max/min representable (SAT=1) or keep the wrapped sum (SAT=0).
REQ-022 SHALL, on an accepted beat with iLast=1, enter DONE; in the next cycle oRes SHALL equal the final acc, oOvf SHALL equal the tile flag and oResValid SHALL be 1.
REQ-023 SHALL leave DONE after one cycle: to ACC if that cycle accepted iClr=1 with iLast=0, to DONE again if iClr=1 with iLast=1, else to IDLE; back-to-back tiles SHALL have no bubble.
REQ-024 SHALL hold oRes and oOvf stable between oResValid pulses.
REQ-025 SHALL treat iClr=1 arriving in ACC as abandoning the open tile without a result pulse.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear oRow, oCol, oValid, oClr, oLast, oRes, oResValid, oOvf, acc and the tile flag to 0 and set state to IDLE.
REQ-027 SHALL, when reset asserts mid-tile, discard the tile; the first beat after release SHALL need iClr=1 to start accumulating.

Structure
REQ-028 SHALL place the state enumeration and saturation-limit constant functions in shared package pe_pkg.
REQ-029 SHALL implement multiply, extend and saturating add in combinational sub-module pe_mac, instantiated once.

Verification
REQ-030 Unsigned, BW=8: beats (3,4,clr),(5,6),(7,8,last) -> oResValid one cycle after last beat, oRes=98, oOvf=0.
REQ-031 SIGNED=1: beats (-3,4,clr),(2,-5,last) -> oRes = -22 (two's complement in ACC_W), oOvf=0.
REQ-032 ACC_W=16, SAT=1, unsigned: 3 beats of (255,255) clr..last -> oRes=65535, oOvf=1; same with SAT=0 -> oRes=64003 (195075 mod 65536), oOvf=1.
REQ-033 Single-beat tile (9,9,clr+last) immediately followed by (2,2,clr+last) -> two consecutive oResValid pulses, oRes=81 then 4.
REQ-034 Reset asserted after 2 of 3 beats, then beat (1,1) without clr, then (2,3,clr+last) -> no pulse for the first, single pulse oRes=6; all outputs 0 during reset.
REQ-035 Random iRow/iCol with iValid toggling -> oRow/oCol/oValid/oClr/oLast equal inputs delayed exactly 1 cycle.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the processing-element accumulator:
//               FSM state encoding and constant functions that build the
//               saturation limits for a given accumulator width/signedness.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Widest accumulator the limit functions can describe.
    localparam int PE_MAX_W = 64;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;  // no tile open
    localparam logic [1:0] ST_ACC  = 2'd1;  // tile open, accumulating
    localparam logic [1:0] ST_DONE = 2'd2;  // result pulse cycle

    // Largest representable value of a w-bit accumulator, LSB-aligned in a
    // PE_MAX_W-bit word (caller truncates to its own width).
    function automatic logic [PE_MAX_W-1:0] sat_max(input int w, input bit is_signed);
        logic [PE_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < PE_MAX_W; i++) begin
            if ((i < w) && !(is_signed && (i == w - 1))) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Smallest representable value: 0 when unsigned, only the sign bit set
    // when two's complement.
    function automatic logic [PE_MAX_W-1:0] sat_min(input int w, input bit is_signed);
        logic [PE_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < PE_MAX_W; i++) begin
            if (is_signed && (i == w - 1)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_if
// Description : Neighbour bus of one systolic processing element. The PE
//               (slave) receives operands/beat flags from west/north and
//               drives the forwarded copies plus the tile result.
// Signals     : iRow/iCol     operands in          (BW)
//               iValid/iClr/iLast  beat flags in
//               oRow/oCol     forwarded operands   (BW)
//               oValid/oClr/oLast  forwarded flags
//               oRes          last tile result     (ACC_W)
//               oResValid     result update pulse
//               oOvf          overflow of tile in oRes
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_acc_if #(
    parameter int BW    = 8,
    parameter int ACC_W = 32
);
    logic [BW-1:0]    iRow;
    logic [BW-1:0]    iCol;
    logic             iValid;
    logic             iClr;
    logic             iLast;
    logic [BW-1:0]    oRow;
    logic [BW-1:0]    oCol;
    logic             oValid;
    logic             oClr;
    logic             oLast;
    logic [ACC_W-1:0] oRes;
    logic             oResValid;
    logic             oOvf;

    // Processing element side
    modport slave (
        input  iRow, iCol, iValid, iClr, iLast,
        output oRow, oCol, oValid, oClr, oLast, oRes, oResValid, oOvf
    );

    // Source / observer side
    modport master (
        output iRow, iCol, iValid, iClr, iLast,
        input  oRow, oCol, oValid, oClr, oLast, oRes, oResValid, oOvf
    );
endinterface : pe_acc_if
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac
// Description : Combinational multiply / extend / accumulate datapath.
//               Product is formed at 2*BW bits, extended to ACC_W and either
//               loaded (load_i) or added to acc_i with overflow detection and
//               optional clamping.
// Ports       : a_i, b_i   operands                       (BW)
//               acc_i      current accumulator            (ACC_W)
//               load_i     1 = result is the product alone
//               sum_o      next accumulator value         (ACC_W)
//               ovf_o      the add overflowed ACC_W
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac
    import pe_pkg::*;
#(
    parameter int BW     = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  wire logic [BW-1:0]    a_i,
    input  wire logic [BW-1:0]    b_i,
    input  wire logic [ACC_W-1:0] acc_i,
    input  wire logic             load_i,
    output logic      [ACC_W-1:0] sum_o,
    output logic                  ovf_o
);

    localparam logic [PE_MAX_W-1:0] c_max_full = sat_max(ACC_W, SIGNED != 0);
    localparam logic [PE_MAX_W-1:0] c_min_full = sat_min(ACC_W, SIGNED != 0);
    localparam logic [ACC_W-1:0]    c_sat_max  = c_max_full[ACC_W-1:0];
    localparam logic [ACC_W-1:0]    c_sat_min  = c_min_full[ACC_W-1:0];

    logic [2*BW-1:0]  w_a_ext;
    logic [2*BW-1:0]  w_b_ext;
    logic [2*BW-1:0]  w_prod;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W:0]   w_raw;
    logic             w_ovf;
    logic [ACC_W-1:0] w_clamp;

    // Operands are widened to 2*BW first so the truncated product is exact
    // for both signed and unsigned interpretation.
    assign w_prod = w_a_ext * w_b_ext;
    assign w_raw  = {1'b0, acc_i} + {1'b0, w_term};

    generate
        if (SIGNED != 0) begin : g_signed
            logic w_unused_carry;
            assign w_a_ext = {{BW{a_i[BW-1]}}, a_i};
            assign w_b_ext = {{BW{b_i[BW-1]}}, b_i};
            assign w_term  = ACC_W'($signed(w_prod));
            // Overflow only when both addends share a sign the sum lacks.
            assign w_ovf   = (acc_i[ACC_W-1] == w_term[ACC_W-1]) &&
                             (w_raw[ACC_W-1] != acc_i[ACC_W-1]);
            // Direction of overflow follows the common sign of the addends.
            assign w_clamp = acc_i[ACC_W-1] ? c_sat_min : c_sat_max;
            assign w_unused_carry = w_raw[ACC_W];
        end else begin : g_unsigned
            logic [ACC_W-1:0] w_unused_min;
            assign w_a_ext = {{BW{1'b0}}, a_i};
            assign w_b_ext = {{BW{1'b0}}, b_i};
            assign w_term  = ACC_W'(w_prod);
            assign w_ovf   = w_raw[ACC_W];
            // Products are non-negative, so only the upper limit is reachable.
            assign w_clamp = c_sat_max;
            assign w_unused_min = c_sat_min;
        end
    endgenerate

    always_comb begin
        sum_o = w_raw[ACC_W-1:0];
        ovf_o = 1'b0;
        if (load_i) begin
            sum_o = w_term;
        end else if (w_ovf) begin
            ovf_o = 1'b1;
            if (SAT != 0) begin
                sum_o = w_clamp;
            end
        end
    end

endmodule : pe_mac
`default_nettype wire

// File: rtl/pe_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc
// Description : Systolic-array processing element. Forwards operands and
//               beat flags to east/south with one cycle latency and
//               accumulates iRow*iCol over a tile delimited by iClr/iLast,
//               publishing the tile result with a one-cycle pulse.
// Ports       : clk        clock, rising edge
//               rst_n      asynchronous active-low reset
//               bus        pe_acc_if.slave: operands/flags in, forwarded
//                          copies, oRes / oResValid / oOvf out
// Revision    : 1.0 - initial release
// ============================================================================
module pe_acc
    import pe_pkg::*;
#(
    parameter int BW     = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    pe_acc_if.slave   bus
);

    generate
        if (ACC_W < 2 * BW) begin : g_chk_acc_w
            $error("pe_acc: ACC_W must be at least 2*BW");
        end
        if (ACC_W > PE_MAX_W) begin : g_chk_max_w
            $error("pe_acc: ACC_W exceeds PE_MAX_W");
        end
    endgenerate

    // Forwarding pipeline
    logic [BW-1:0]    row_q;
    logic [BW-1:0]    col_q;
    logic             valid_q;
    logic             clr_q;
    logic             last_q;

    // Accumulation state
    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic             flag_q,  flag_d;
    logic [ACC_W-1:0] res_q,   res_d;
    logic             ovf_q,   ovf_d;
    logic             res_valid_q, res_valid_d;

    logic [ACC_W-1:0] w_mac_sum;
    logic             w_mac_ovf;

    pe_mac #(
        .BW     (BW),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_mac (
        .a_i    (bus.iRow),
        .b_i    (bus.iCol),
        .acc_i  (acc_q),
        .load_i (bus.iClr),
        .sum_o  (w_mac_sum),
        .ovf_o  (w_mac_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        flag_d      = flag_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;

        // DONE lasts one cycle; an unused encoding also falls back to IDLE.
        if ((state_q != ST_IDLE) && (state_q != ST_ACC)) begin
            state_d = ST_IDLE;
        end

        if (bus.iValid) begin
            if (bus.iClr) begin
                // Starts a new tile from any state; an open tile is dropped.
                acc_d   = w_mac_sum;
                flag_d  = 1'b0;
                state_d = ST_ACC;
            end else if (state_q == ST_ACC) begin
                acc_d   = w_mac_sum;
                flag_d  = flag_q | w_mac_ovf;
            end

            // Only a beat that belongs to a tile can close it.
            if (bus.iLast && (bus.iClr || (state_q == ST_ACC))) begin
                state_d     = ST_DONE;
                res_d       = acc_d;
                ovf_d       = flag_d;
                res_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            valid_q     <= 1'b0;
            clr_q       <= 1'b0;
            last_q      <= 1'b0;
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            flag_q      <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            row_q       <= bus.iRow;
            col_q       <= bus.iCol;
            valid_q     <= bus.iValid;
            clr_q       <= bus.iClr;
            last_q      <= bus.iLast;
            state_q     <= state_d;
            acc_q       <= acc_d;
            flag_q      <= flag_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.oRow      = row_q;
    assign bus.oCol      = col_q;
    assign bus.oValid    = valid_q;
    assign bus.oClr      = clr_q;
    assign bus.oLast     = last_q;
    assign bus.oRes      = res_q;
    assign bus.oResValid = res_valid_q;
    assign bus.oOvf      = ovf_q;

endmodule : pe_acc
`default_nettype wire
